// File: rtl/rbz_pkg.sv
// rtl/rbz_pkg.sv - shared raycaster constants, wall record type and colour helper
package rbz_pkg;

  localparam int H_VIEW_DEF = 640;
  localparam int V_VIEW_DEF = 480;

  localparam int COLOR_W  = 6;
  localparam int HEIGHT_W = 10;
  localparam int POS_W    = 10;

  localparam logic [COLOR_W-1:0] CEIL_COLOR_DEF  = 6'b01_01_01;
  localparam logic [COLOR_W-1:0] FLOOR_COLOR_DEF = 6'b10_10_10;

  typedef struct packed {
    logic [HEIGHT_W-1:0] height;
    logic                side;
    logic [COLOR_W-1:0]  color;
  } wall_rec_t;

  // Darken an rrggbb colour by halving each 2-bit channel independently.
  function automatic logic [COLOR_W-1:0] shade_color(input logic [COLOR_W-1:0] c);
    return {1'b0, c[5], 1'b0, c[3], 1'b0, c[1]};
  endfunction

endpackage

// File: rtl/rbz_span_calc.sv
// rtl/rbz_span_calc.sv - maps a wall height to its centred [start, end) pixel span
module rbz_span_calc
  import rbz_pkg::*;
#(
  parameter int H_VIEW = H_VIEW_DEF
) (
  input  logic [HEIGHT_W-1:0] i_height,
  output logic [POS_W-1:0]    o_start,
  output logic [POS_W-1:0]    o_end
);

  localparam logic [HEIGHT_W-1:0] H_LIMIT = HEIGHT_W'(H_VIEW);
  localparam logic [POS_W-1:0]    MID     = POS_W'(H_VIEW / 2);

  logic [HEIGHT_W-1:0] w_h;
  logic [HEIGHT_W-1:0] w_half;

  // A wall taller than the screen just fills it; the half-height then never exceeds MID.
  assign w_h     = (i_height > H_LIMIT) ? H_LIMIT : i_height;
  assign w_half  = w_h >> 1;
  assign o_start = MID - w_half;
  assign o_end   = MID + w_half;

endmodule

// File: rtl/rbz_span_shader.sv
// rtl/rbz_span_shader.sv - per-pixel ceiling/wall/floor shader with one-record-per-line handshake
module rbz_span_shader
  import rbz_pkg::*;
#(
  parameter int                 H_VIEW      = H_VIEW_DEF,
  parameter int                 V_VIEW      = V_VIEW_DEF,
  parameter logic [COLOR_W-1:0] CEIL_COLOR  = CEIL_COLOR_DEF,
  parameter logic [COLOR_W-1:0] FLOOR_COLOR = FLOOR_COLOR_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [POS_W-1:0]    hpos,
  input  logic [POS_W-1:0]    vpos,
  input  logic                hmax,
  input  logic                vmax,
  input  logic                visible,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [HEIGHT_W-1:0] rec_height,
  input  logic                rec_side,
  input  logic [COLOR_W-1:0]  rec_color,
  input  logic                clear_underrun,
  output logic [COLOR_W-1:0]  rgb,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [7:0]          underrun_count
);

  localparam logic [POS_W-1:0] MID = POS_W'(H_VIEW / 2);

  wall_rec_t          r_pending;
  logic               r_pending_full;
  logic [POS_W-1:0]   r_start;
  logic [POS_W-1:0]   r_end;
  logic [COLOR_W-1:0] r_color;
  logic               r_side;
  logic               r_run;
  logic [7:0]         r_underrun;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_hsync;
  logic               r_vsync;

  logic               w_handshake;
  logic               w_next_vis;
  logic               w_commit;
  logic               w_bypass;
  logic               w_underrun;
  wall_rec_t          w_incoming;
  wall_rec_t          w_commit_rec;
  logic [POS_W-1:0]   w_span_start;
  logic [POS_W-1:0]   w_span_end;
  logic [COLOR_W-1:0] w_pixel;

  assign rec_ready   = r_run & ~r_pending_full;
  assign w_handshake = rec_valid & rec_ready;
  assign w_incoming  = {rec_height, rec_side, rec_color};

  // The line after this one is visible either on frame wrap or while still above V_VIEW.
  assign w_next_vis = vmax | (({1'b0, vpos} + 11'd1) < 11'(V_VIEW));
  assign w_commit   = hmax & w_next_vis;
  assign w_bypass   = w_commit & ~r_pending_full & w_handshake;
  assign w_underrun = w_commit & ~r_pending_full & ~w_handshake;

  // Record that becomes active at commit: queued one first, then a same-cycle arrival,
  // otherwise an empty wall that keeps the last colour.
  always_comb begin
    w_commit_rec = r_pending;
    if (!r_pending_full) begin
      if (w_handshake) begin
        w_commit_rec = w_incoming;
      end else begin
        w_commit_rec = {{HEIGHT_W{1'b0}}, r_side, r_color};
      end
    end
  end

  rbz_span_calc #(
    .H_VIEW(H_VIEW)
  ) u_span_calc (
    .i_height(w_commit_rec.height),
    .o_start (w_span_start),
    .o_end   (w_span_end)
  );

  // Accept records into the pending slot and move them to the active span at line end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run          <= 1'b0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_start        <= MID;
      r_end          <= MID;
      r_color        <= '0;
      r_side         <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_commit) begin
        r_start <= w_span_start;
        r_end   <= w_span_end;
        r_color <= w_commit_rec.color;
        r_side  <= w_commit_rec.side;
      end
      if (w_commit && r_pending_full) begin
        r_pending_full <= 1'b0;
      end else if (w_handshake && !w_bypass) begin
        r_pending      <= w_incoming;
        r_pending_full <= 1'b1;
      end
    end
  end

  // Saturating underrun counter; an explicit clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= '0;
    end else if (clear_underrun) begin
      r_underrun <= '0;
    end else if (w_underrun && (r_underrun != 8'hFF)) begin
      r_underrun <= r_underrun + 8'd1;
    end
  end

  // Classify the current pixel against the active span.
  always_comb begin
    w_pixel = '0;
    if (visible) begin
      if (hpos < r_start) begin
        w_pixel = CEIL_COLOR;
      end else if (hpos < r_end) begin
        w_pixel = r_side ? shade_color(r_color) : r_color;
      end else begin
        w_pixel = FLOOR_COLOR;
      end
    end
  end

  // Single output stage so colour and syncs leave on the same clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb   <= '0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_rgb   <= w_pixel;
      r_hsync <= hsync_in;
      r_vsync <= vsync_in;
    end
  end

  assign rgb            = r_rgb;
  assign hsync_out      = r_hsync;
  assign vsync_out      = r_vsync;
  assign underrun_count = r_underrun;

endmodule

// File: tb/tb_rbz_span_shader.sv
// tb/tb_rbz_span_shader.sv - self-checking bench for rbz_span_shader
module tb_rbz_span_shader;

  localparam int HT  = 660;
  localparam int HS0 = 648;
  localparam int HS1 = 656;
  localparam int VT  = 483;
  localparam int VS0 = 481;
  localparam int VS1 = 482;

  localparam int C_CEIL  = 'b010101;
  localparam int C_FLOOR = 'b101010;

  typedef struct {
    int height;
    int color;
    bit side;
  } rec_s;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       hmax = 1'b0;
  logic       vmax = 1'b0;
  logic       visible = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       rec_valid = 1'b0;
  logic       rec_ready;
  logic [9:0] rec_height = '0;
  logic       rec_side = 1'b0;
  logic [5:0] rec_color = '0;
  logic       clear_underrun = 1'b0;
  logic [5:0] rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic [7:0] underrun_count;

  int n_checks = 0;
  int n_errors = 0;

  int cap[HT];

  bit   arm_rec = 0;
  int   arm_v, arm_h;
  rec_s arm_data;
  bit   arm_clr = 0;
  int   clr_v, clr_h;

  always #5 clk = ~clk;

  rbz_span_shader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hpos          (hpos),
    .vpos          (vpos),
    .hmax          (hmax),
    .vmax          (vmax),
    .visible       (visible),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_height    (rec_height),
    .rec_side      (rec_side),
    .rec_color     (rec_color),
    .clear_underrun(clear_underrun),
    .rgb           (rgb),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .underrun_count(underrun_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pixel(input int h, input bit vis, input rec_s a);
    int hh, s, e, r, g, b;
    if (!vis) return 0;
    hh = (a.height > 640) ? 640 : a.height;
    s = 320 - hh / 2;
    e = 320 + hh / 2;
    if (h < s) return C_CEIL;
    if (h < e) begin
      if (!a.side) return a.color;
      r = (a.color / 16) % 4;
      g = (a.color / 4) % 4;
      b = a.color % 4;
      return (r / 2) * 16 + (g / 2) * 4 + (b / 2);
    end
    return C_FLOOR;
  endfunction

  // Reference model and per-cycle comparison of every output.
  rec_s m_act = '{height: 0, color: 0, side: 1'b0};
  rec_s m_q[$];
  bit   m_run = 0;
  int   m_cnt = 0;

  always @(posedge clk) begin : monitor
    int   s_h, e_rgb, e_hs, e_vs;
    bit   hs, nv;
    rec_s inc;
    s_h = int'(hpos);
    if (!reset_n) begin
      m_act = '{height: 0, color: 0, side: 1'b0};
      m_q.delete();
      m_run = 0;
      m_cnt = 0;
      e_rgb = 0;
      e_hs  = 0;
      e_vs  = 0;
    end else begin
      e_rgb = model_pixel(int'(hpos), visible, m_act);
      e_hs  = int'(hsync_in);
      e_vs  = int'(vsync_in);
      hs    = rec_valid && m_run && (m_q.size() == 0);
      inc   = '{height: int'(rec_height), color: int'(rec_color), side: rec_side};
      nv    = vmax || (int'(vpos) + 1 < 480);
      if (hmax && nv) begin
        if (m_q.size() > 0) begin
          m_act = m_q.pop_front();
        end else if (hs) begin
          m_act = inc;
          hs = 0;
        end else begin
          m_act.height = 0;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (clear_underrun) m_cnt = 0;
      if (hs) m_q.push_back(inc);
      m_run = 1;
    end
    #1;
    chk("rgb", int'(rgb), e_rgb);
    chk("hsync_out", int'(hsync_out), e_hs);
    chk("vsync_out", int'(vsync_out), e_vs);
    chk("underrun_count", int'(underrun_count), m_cnt);
    chk("rec_ready", int'(rec_ready), (m_run && m_q.size() == 0) ? 1 : 0);
    if (s_h < HT) cap[s_h] = int'(rgb);
  end

  task automatic step(input int v, input int h);
    bit hs_now;
    hpos     = 10'(h);
    vpos     = 10'(v);
    visible  = (h < 640) && (v < 480);
    hmax     = (h == HT - 1);
    vmax     = (v == VT - 1);
    hsync_in = (h >= HS0) && (h < HS1);
    vsync_in = (v >= VS0) && (v < VS1);
    clear_underrun = arm_clr && (v == clr_v) && (h == clr_h);
    if (arm_rec && v == arm_v && h == arm_h) begin
      rec_valid  = 1'b1;
      rec_height = 10'(arm_data.height);
      rec_color  = 6'(arm_data.color);
      rec_side   = arm_data.side;
      arm_rec    = 0;
    end
    hs_now = rec_valid && rec_ready;
    @(posedge clk);
    #2;
    if (hs_now) rec_valid = 1'b0;
  endtask

  task automatic run_line(input int v);
    for (int h = 0; h < HT; h++) step(v, h);
  endtask

  task automatic arm_record(input int v, input int h, input int height, input int color, input bit side);
    arm_rec  = 1;
    arm_v    = v;
    arm_h    = h;
    arm_data = '{height: height, color: color, side: side};
  endtask

  task automatic arm_clear(input int v, input int h);
    arm_clr = 1;
    clr_v   = v;
    clr_h   = h;
  endtask

  initial begin
    #3;
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_ready", int'(rec_ready), 0);
    chk("reset_count", int'(underrun_count), 0);

    for (int h = 0; h < 4; h++) step(9, h);
    reset_n = 1'b1;

    // Normal record committed at the end of line 9.
    arm_record(9, 20, 200, 'b110000, 1'b0);
    for (int h = 4; h < HT; h++) step(9, h);

    // Shaded, over-tall record queued during line 10.
    arm_record(10, 30, 900, 'b111111, 1'b1);
    run_line(10);
    chk("l10_ceil_0", cap[0], C_CEIL);
    chk("l10_ceil_219", cap[219], C_CEIL);
    chk("l10_wall_220", cap[220], 'b110000);
    chk("l10_wall_419", cap[419], 'b110000);
    chk("l10_floor_420", cap[420], C_FLOOR);
    chk("l10_floor_639", cap[639], C_FLOOR);
    chk("l10_blank_640", cap[640], 0);
    chk("l10_count", int'(underrun_count), 0);

    run_line(11);
    chk("l11_shade_0", cap[0], 'b010101);
    chk("l11_shade_639", cap[639], 'b010101);
    chk("l11_blank_640", cap[640], 0);

    // Two starved commits.
    run_line(12);
    chk("underrun_two", int'(underrun_count), 2);
    chk("l12_ceil_319", cap[319], C_CEIL);
    chk("l12_floor_320", cap[320], C_FLOOR);

    // Clear, then a handshake landing exactly on hmax.
    arm_clear(13, 100);
    arm_record(13, HT - 1, 100, 'b001100, 1'b0);
    run_line(13);
    chk("clear_count", int'(underrun_count), 0);
    chk("bypass_ready", int'(rec_ready), 1);

    run_line(14);
    chk("l14_ceil_269", cap[269], C_CEIL);
    chk("l14_wall_270", cap[270], 'b001100);
    chk("l14_wall_369", cap[369], 'b001100);
    chk("l14_floor_370", cap[370], C_FLOOR);

    // Bottom of frame, then a record accepted on the last visible line's hmax.
    arm_record(478, 10, 50, 'b000011, 1'b1);
    run_line(478);
    arm_record(479, HT - 1, 3, 'b110011, 1'b0);
    run_line(479);
    chk("vblank_pending_ready", int'(rec_ready), 0);
    chk("l479_ceil_294", cap[294], C_CEIL);
    chk("l479_wall_295", cap[295], 'b000001);
    chk("l479_wall_344", cap[344], 'b000001);
    chk("l479_floor_345", cap[345], C_FLOOR);
    run_line(480);
    run_line(481);
    run_line(482);
    chk("vblank_count", int'(underrun_count), 1);
    chk("wrap_ready", int'(rec_ready), 1);

    run_line(0);
    chk("l0_ceil_318", cap[318], C_CEIL);
    chk("l0_wall_319", cap[319], 'b110011);
    chk("l0_wall_320", cap[320], 'b110011);
    chk("l0_floor_321", cap[321], C_FLOOR);

    // Asynchronous reset in the middle of line 1.
    for (int h = 0; h < 100; h++) step(1, h);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rgb", int'(rgb), 0);
    chk("async_hsync", int'(hsync_out), 0);
    chk("async_vsync", int'(vsync_out), 0);
    chk("async_ready", int'(rec_ready), 0);
    chk("async_count", int'(underrun_count), 0);
    step(1, 100);
    step(1, 101);
    #3;
    reset_n = 1'b1;
    #1;
    chk("release_ready", int'(rec_ready), 0);
    step(1, 102);
    step(1, 103);
    chk("release_ready_2clk", int'(rec_ready), 1);
    for (int h = 104; h < HT; h++) step(1, h);

    // Reset span on line 2, and a clear colliding with an underrun at its hmax.
    arm_clear(2, HT - 1);
    run_line(2);
    chk("l2_ceil_319", cap[319], C_CEIL);
    chk("l2_floor_320", cap[320], C_FLOOR);
    chk("clear_wins", int'(underrun_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rbz_span_shader.md
# rbz_span_shader

Per-pixel colour stage directly downstream of the VGA sync generator. It accepts one wall record per scanline from the ray tracer over a valid/ready handshake and commits it at the end of the preceding line. During the visible line it shades each pixel as ceiling, wall or floor from the sync generator's `hpos`/`vpos`/`visible`. RGB and the sync outputs leave through one register stage, so they stay aligned at the pins.

## Interface
- `H_VIEW`, 640: visible pixels per line.
- `V_VIEW`, 480: visible lines per frame.
- `CEIL_COLOR`, 6'b01_01_01: ceiling colour, rrggbb.
- `FLOOR_COLOR`, 6'b10_10_10: floor colour, rrggbb.
- `clk` in 1: pixel clock, shared with the sync generator.
- `reset_n` in 1: asynchronous reset, active-low.
- `hpos`, `vpos` in 10 each: current beam position.
- `hmax`, `vmax`, `visible` in 1 each: sync generator status.
- `hsync_in`, `vsync_in` in 1 each: sync generator syncs.
- `rec_valid` in 1: tracer record valid.
- `rec_ready` out 1: shader can accept a record.
- `rec_height` in 10: wall height in pixels.
- `rec_side` in 1: 1 means shaded (darkened) side.
- `rec_color` in 6: wall colour, rrggbb.
- `clear_underrun` in 1: synchronous clear of the underrun counter.
- `rgb` out 6: registered pixel colour.
- `hsync_out`, `vsync_out` out 1 each: syncs delayed 1 cycle.
- `underrun_count` out 8: saturating count of lines with no record.

## Operation
- Registers:
  - `pending` record plus `pending_full` flag.
  - `active` record, stored as `start`/`end` span plus colour and side.
  - `run` flag.
- `rec_ready = run & ~pending_full`. `run` is 0 in reset and becomes 1 on the first clock after `reset_n` rises.
- A handshake occurs when `rec_valid & rec_ready`. The record is stored in `pending` and `pending_full` is set to 1.
- `next_vis = vmax ? 1 : (vpos + 1 < V_VIEW)`. `next_vis` is true when the line after the current one is visible.
- Commit happens on a cycle with `hmax & next_vis`:
  - If `pending_full`, then `active <= pending` and `pending_full <= 0`.
  - If a handshake occurs in the same cycle and `pending_full` is 0, the incoming record bypasses `pending` straight into `active`.
  - If neither applies, this is an underrun. `active` becomes height 0 with the previous colour. `underrun_count` increments and saturates at 255.
- On `hmax` with `next_vis` false (vblank): no commit, no underrun, and `pending` is held.
- Span arithmetic, done at commit:
  - `h = min(rec_height, H_VIEW)`.
  - `half = h >> 1`.
  - `start = H_VIEW/2 - half`.
  - `end = H_VIEW/2 + half`, exclusive.
  - Both values are 10 bits and need no further clamping.
- Pixel rule:
  - If `!visible`, the pixel is 0.
  - Else if `hpos < start`, the pixel is `CEIL_COLOR`.
  - Else if `hpos < end`, the pixel is the wall colour. If `side` is 1, each 2-bit channel is shifted right by 1.
  - Else the pixel is `FLOOR_COLOR`.
- `clear_underrun` zeroes the counter. If an underrun occurs in the same cycle, the clear wins.

## Timing
- Reset values:
  - `rgb` = 0, `hsync_out` = 0, `vsync_out` = 0.
  - `underrun_count` = 0, `rec_ready` = 0.
  - `pending_full` = 0.
  - `active`: height 0 (start = end = H_VIEW/2), colour 0, side 0.
- Latency:
  - `rgb`, `hsync_out` and `vsync_out` are each exactly 1 clock after the inputs they derive from.
  - A committed record affects the pixel at `hpos` 0 of the next line.
- At most one record is accepted per commit interval. `rec_ready` falls in the cycle after the handshake.
- Reset asserted mid-line clears all state immediately and asynchronously. After release, the first line drawn is the reset span unless a record was committed in the meantime.
- Frame wrap: `hmax & vmax` commits the record for line 0.

## Structure
- Shared package `rbz_pkg` holds:
  - the rrggbb colour localparams;
  - the wall-record field widths;
  - the `H_VIEW`/`V_VIEW` defaults shared with the sync generator.
- One sub-module, `rbz_span_calc`: combinational; maps height to `start`/`end`.
- The handshake, commit logic and output register stay in the top module.

## Test plan
- **Normal record:** send height 200, colour 6'b110000, side 0 before `hmax` of line 9. Required: line 10 outputs ceiling for `hpos` 0–219, 6'b110000 for 220–419, floor for 420–639, and `rgb` = 0 for `hpos` ≥ 640.
- **Shaded side and clamping:** send height 900 with side 1 and colour 6'b111111. Required: the whole visible line is 6'b010101.
- **Underrun:** hold `rec_valid` low across two visible line commits. Required: `underrun_count` = 2 and the line is split ceiling/floor at `hpos` 320. Then assert `clear_underrun`. Required: count = 0.
- **Bypass and vblank:** make the handshake land exactly on the `hmax` cycle. Required: the record is used on the next line. Handshake at `vpos` 479 on `hmax`: no commit, `pending` held, and the record is drawn on line 0 after the `vmax` wrap. Required: no underruns counted during vblank.
- **Reset mid-line:** pulse `reset_n` low at `hpos` 100. Required: `rgb`, `hsync_out`, `vsync_out` and `rec_ready` go to 0 asynchronously. `rec_ready` = 1 on the second clock after release.
- **Sync alignment:** check every cycle of a full frame. Required: `hsync_out` and `vsync_out` equal `hsync_in` and `vsync_in` delayed by exactly 1 cycle.
